// File: rtl/csa_ctrl_pkg.sv
// Shared definitions for the sequential carry-select adder controller:
// FSM state encoding and a constant clog2 helper for sizing counters.
package csa_ctrl_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Never returns less than 1 so that a single-slice counter still has a bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/csa_seq_adder_if.sv
// Operand/result handshake bundle between a requester and the sequential adder.
interface csa_seq_adder_if #(parameter int W = 32);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         busy;

  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, busy
  );

  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, busy
  );

endinterface

// File: rtl/CSA.sv
// N-bit carry-select adder slice: the low half ripples, the high half is
// precomputed for both carries and selected by the low-half carry-out.
module CSA #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  if (N == 1) begin : g_bit
    logic [1:0] total;
    assign total = {1'b0, a} + {1'b0, b} + {1'b0, ci};
    assign sum   = total[0];
    assign co    = total[1];
  end else begin : g_select
    localparam int L = N / 2;
    localparam int H = N - L;

    logic [L:0] lo;
    logic [H:0] hi0;
    logic [H:0] hi1;

    assign lo  = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]} + (L+1)'(ci);
    assign hi0 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]};
    assign hi1 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]} + (H+1)'(1);
    assign sum = {(lo[L] ? hi1[H-1:0] : hi0[H-1:0]), lo[L-1:0]};
    assign co  = lo[L] ? hi1[H] : hi0[H];
  end

endmodule

// File: rtl/csa_seq_adder.sv
// Multi-cycle W-bit adder that time-shares one N-bit CSA slice, processing
// the least-significant slice first and carrying between slices in a flop.
module csa_seq_adder
  import csa_ctrl_pkg::*;
#(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  csa_seq_adder_if.slave  bus
);

  localparam int S  = (N < 1) ? 1 : W / N;
  localparam int CW = clog2(S);

  if ((N < 1) || ((W % N) != 0)) begin : g_param_err
    $error("csa_seq_adder: W must be a positive multiple of N");
  end

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  slice_sum;
  logic          slice_co;
  logic [W-1:0]  full_sum;
  logic          last_slice;

  CSA #(.N(N)) u_csa (
    .a   (a_q[N-1:0]),
    .b   (b_q[N-1:0]),
    .ci  (carry_q),
    .sum (slice_sum),
    .co  (slice_co)
  );

  // Completed slices collect in part_q; the current slice lands on top of it.
  if (S > 1) begin : g_part
    logic [W-N-1:0] part_q, part_d;

    assign full_sum = {slice_sum, part_q};

    always_comb begin
      part_d = part_q;
      if (state_q == RUN) part_d = full_sum[W-1:N];
    end

    always_ff @(posedge clk) begin
      if (!reset_n) part_q <= '0;
      else          part_q <= part_d;
    end
  end else begin : g_single
    assign full_sum = slice_sum;
  end

  assign last_slice = (cnt_q == CW'(S - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.ci;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> N;
        b_d     = b_q >> N;
        carry_d = slice_co;
        cnt_d   = cnt_q + CW'(1);
        // The visible result only moves once, when the top slice completes.
        if (last_slice) begin
          sum_d   = full_sum;
          co_d    = slice_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;

endmodule

// File: tb/tb_csa_seq_adder.sv
// Self-checking bench for csa_seq_adder: directed W=16/N=4 and W=N=8 cases,
// then a scoreboarded random run on W=32/N=8 with handshake stalls.
module tb_csa_seq_adder;

  logic clk;
  logic reset_n;

  int compared   = 0;
  int mismatched = 0;

  logic [16:0] q16[$];
  logic [8:0]  q8[$];
  logic [32:0] q32[$];

  csa_seq_adder_if #(.W(16)) bus16 ();
  csa_seq_adder_if #(.W(8))  bus8 ();
  csa_seq_adder_if #(.W(32)) bus32 ();

  csa_seq_adder #(.W(16), .N(4)) dut16 (.clk(clk), .reset_n(reset_n), .bus(bus16));
  csa_seq_adder #(.W(8),  .N(8)) dut8  (.clk(clk), .reset_n(reset_n), .bus(bus8));
  csa_seq_adder #(.W(32), .N(8)) dut32 (.clk(clk), .reset_n(reset_n), .bus(bus32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Runs one W=16 operation; noise toggles in_valid with junk operands while
  // busy, and hold keeps out_ready low for that many cycles in DONE.
  task automatic applyStimulus(input string tag, input logic [15:0] a,
                               input logic [15:0] b, input logic ci,
                               input bit noise, input int hold);
    int          cyc;
    bit          ready_low;
    bit          stable;
    logic [15:0] s0;
    logic        c0;
    logic [16:0] exp;
    q16.push_back({1'b0, a} + {1'b0, b} + {16'd0, ci});
    @(posedge clk); #1;
    bus16.in_valid = 1'b1;
    bus16.a = a;
    bus16.b = b;
    bus16.ci = ci;
    bus16.out_ready = 1'b0;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    cyc = 0;
    ready_low = 1'b1;
    while (!bus16.out_valid && cyc < 20) begin
      if (bus16.in_ready) ready_low = 1'b0;
      if (noise) begin
        bus16.in_valid = cyc[0];
        bus16.a = 16'($urandom);
        bus16.b = 16'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, " latency"}, 64'(cyc), 64'd4);
    checkOutput({tag, " in_ready low in RUN"}, 64'(ready_low), 64'd1);
    checkOutput({tag, " in_ready low in DONE"}, 64'(bus16.in_ready), 64'd0);
    s0 = bus16.sum;
    c0 = bus16.co;
    stable = 1'b1;
    repeat (hold) begin
      if (noise) begin
        bus16.in_valid = ~bus16.in_valid;
        bus16.a = 16'($urandom);
      end
      @(posedge clk); #1;
      if (bus16.sum !== s0 || bus16.co !== c0 || bus16.out_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) checkOutput({tag, " stable under backpressure"}, 64'(stable), 64'd1);
    exp = q16.pop_front();
    checkOutput({tag, " sum"}, 64'(bus16.sum), 64'(exp[15:0]));
    checkOutput({tag, " co"}, 64'(bus16.co), 64'(exp[16]));
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    checkOutput({tag, " out_valid after handshake"}, 64'(bus16.out_valid), 64'd0);
    checkOutput({tag, " in_ready after handshake"}, 64'(bus16.in_ready), 64'd1);
  endtask

  initial begin
    int          cyc;
    int          accepted;
    int          produced;
    logic [8:0]  exp8;
    logic [32:0] exp32;

    reset_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0; bus16.out_ready = 1'b0;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.ci  = 1'b0; bus8.out_ready  = 1'b0;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.ci = 1'b0; bus32.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("reset in_ready", 64'(bus16.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus16.out_valid), 64'd0);
    checkOutput("reset busy", 64'(bus16.busy), 64'd0);
    checkOutput("reset sum", 64'(bus16.sum), 64'd0);
    checkOutput("reset co", 64'(bus16.co), 64'd0);

    $display("[TB] W=16 N=4 directed operations");
    applyStimulus("ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    applyStimulus("1234+4321+1", 16'h1234, 16'h4321, 1'b1, 1'b0, 0);
    applyStimulus("backpressure", 16'hA5A5, 16'h1111, 1'b1, 1'b1, 5);

    $display("[TB] reset in the middle of an operation");
    q16.push_back({1'b0, 16'h0F0F} + {1'b0, 16'h0101});
    @(posedge clk); #1;
    bus16.in_valid = 1'b1; bus16.a = 16'h0F0F; bus16.b = 16'h0101; bus16.ci = 1'b0;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("midrun busy", 64'(bus16.busy), 64'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    void'(q16.pop_front());
    checkOutput("midrun reset in_ready", 64'(bus16.in_ready), 64'd1);
    checkOutput("midrun reset out_valid", 64'(bus16.out_valid), 64'd0);
    checkOutput("midrun reset busy", 64'(bus16.busy), 64'd0);
    checkOutput("midrun reset sum", 64'(bus16.sum), 64'd0);
    checkOutput("midrun reset co", 64'(bus16.co), 64'd0);
    @(posedge clk); #1;
    checkOutput("midrun stays idle", 64'(bus16.busy), 64'd0);
    applyStimulus("after reset", 16'h8000, 16'h8000, 1'b1, 1'b0, 0);

    $display("[TB] reset colliding with a handshake");
    @(posedge clk); #1;
    bus16.in_valid = 1'b1; bus16.a = 16'h0001; bus16.b = 16'h0001; bus16.ci = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus16.in_valid = 1'b0;
    checkOutput("reset+accept busy", 64'(bus16.busy), 64'd0);
    checkOutput("reset+accept in_ready", 64'(bus16.in_ready), 64'd1);
    checkOutput("reset+accept sum", 64'(bus16.sum), 64'd0);

    $display("[TB] W=N=8 single-slice operation");
    q8.push_back({1'b0, 8'h80} + {1'b0, 8'h80});
    @(posedge clk); #1;
    bus8.in_valid = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80; bus8.ci = 1'b0;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    checkOutput("w8 busy after accept", 64'(bus8.busy), 64'd1);
    checkOutput("w8 out_valid after accept", 64'(bus8.out_valid), 64'd0);
    @(posedge clk); #1;
    checkOutput("w8 out_valid one cycle later", 64'(bus8.out_valid), 64'd1);
    exp8 = q8.pop_front();
    checkOutput("w8 sum", 64'(bus8.sum), 64'(exp8[7:0]));
    checkOutput("w8 co", 64'(bus8.co), 64'(exp8[8]));
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
    checkOutput("w8 idle after handshake", 64'(bus8.in_ready), 64'd1);

    $display("[TB] W=32 N=8 random run with stalls");
    accepted = 0;
    produced = 0;
    cyc = 0;
    while ((accepted < 1000 || q32.size() != 0) && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
      bus32.in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      bus32.a         = $urandom;
      bus32.b         = $urandom;
      bus32.ci        = 1'($urandom_range(0, 1));
      bus32.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back({1'b0, bus32.a} + {1'b0, bus32.b} + {32'd0, bus32.ci});
        accepted++;
      end
      if (bus32.out_valid && bus32.out_ready) begin
        produced++;
        if (q32.size() == 0) begin
          checkOutput("rand unexpected result", 64'(bus32.sum), 64'hDEAD_0000_0000_0000);
        end else begin
          exp32 = q32.pop_front();
          checkOutput("rand sum", 64'(bus32.sum), 64'(exp32[31:0]));
          checkOutput("rand co", 64'(bus32.co), 64'(exp32[32]));
        end
      end
    end
    checkOutput("rand finished in budget", 64'(cyc < 40000), 64'd1);
    checkOutput("rand results per accept", 64'(produced), 64'(accepted));
    checkOutput("rand accepted count", 64'(accepted), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
